// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the tinymips multicycle controller.
// Optional bne support is selected by the MIPS_MC_BNE_EN macro in mips_mc_control.
package mips_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned WAIT_W  = 8;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  typedef enum logic [ALU_W-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    AOP_ADD   = 2'b00,
    AOP_SUB   = 2'b01,
    AOP_FUNCT = 2'b10
  } aluop_t;

endpackage

// File: rtl/mips_alu_dec.sv
// ALU decoder: maps aluop and FUNCT to an ALU control code, flagging unknown functs.
module mips_alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [1:0]         aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALU_W-1:0]   alu_control,
  output logic               illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (aluop)
      AOP_SUB: alu_control = ALU_SUB;
      AOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle main controller for tinymips: per-cycle datapath controls with MEM_READY stalls.
// Define MIPS_MC_BNE_EN to decode bne (opcode 000101) as a branch on ~zero.
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 16,
  parameter bit          ILLEGAL_TRAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcen,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               mem2reg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALU_W-1:0]   alu_control,
  output logic               halted,
  output logic               err
);

  localparam state_t ILLEGAL_NEXT = ILLEGAL_TRAP ? S_HALT : S_FETCH;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              err_next;
  logic [1:0]        aluop;
  logic              alu_illegal;
  logic              pcwrite, branch_sel, bne_sel, waiting, timeout_hit;

  mips_alu_dec u_alu_dec (
    .aluop       (aluop),
    .funct       (funct),
    .alu_control (alu_control),
    .illegal     (alu_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      err      <= err_next;
    end
  end

  always_comb begin
    state_next  = state;
    iord        = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 1'b0;
    mem2reg     = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    aluop       = AOP_ADD;
    pcwrite     = 1'b0;
    branch_sel  = 1'b0;
    bne_sel     = 1'b0;
    halted      = 1'b0;
    waiting     = 1'b0;
    timeout_hit = 1'b0;

    case (state)
      S_FETCH: begin
        // Gated by rst_n so reset never shows an instruction load.
        alusrcb = 2'b01;
        irwrite = mem_ready & rst_n;
        pcwrite = mem_ready & rst_n;
        waiting = 1'b1;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       state_next = S_BRANCH;
`endif
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = ILLEGAL_NEXT;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        waiting = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem2reg    = 1'b1;
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        waiting  = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        aluop      = AOP_FUNCT;
        state_next = alu_illegal ? ILLEGAL_NEXT : S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = AOP_SUB;
        pcsrc   = 2'b01;
`ifdef MIPS_MC_BNE_EN
        if (opcode == OP_BNE) bne_sel = 1'b1;
        else                  branch_sel = 1'b1;
`else
        branch_sel = 1'b1;
`endif
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_FETCH;
    endcase

    // A ready response on the last allowed cycle beats the timeout.
    if (waiting && !mem_ready && (wait_cnt == WAIT_W'(TIMEOUT - 1))) begin
      timeout_hit = 1'b1;
      state_next  = S_HALT;
    end

    wait_cnt_next = (waiting && !mem_ready && (state_next == state)) ?
                    wait_cnt + WAIT_W'(1) : '0;
    err_next      = err | timeout_hit;
    pcen          = pcwrite | (branch_sel & zero) | (bne_sel & ~zero);
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: per-cycle output vectors checked against hand-derived values.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pcen, iord, memwrite, irwrite, regdst, mem2reg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alu_control;
  logic       halted, err;
  logic [16:0] obs;
  int checks = 0;
  int failures = 0;

  localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_R = 6'b000000,
                         T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000,
                         T_J = 6'b000010, T_BAD = 6'b111111;

  // {pcen,iord,memwrite,irwrite,regdst,mem2reg,regwrite,alusrca,alusrcb,pcsrc,alu_control,halted,err}
  localparam logic [16:0] E_FETCH_W  = 17'b0_0_0_0_0_0_0_0_01_00_010_0_0;
  localparam logic [16:0] E_FETCH_R  = 17'b1_0_0_1_0_0_0_0_01_00_010_0_0;
  localparam logic [16:0] E_DECODE   = 17'b0_0_0_0_0_0_0_0_11_00_010_0_0;
  localparam logic [16:0] E_MEMADR   = 17'b0_0_0_0_0_0_0_1_10_00_010_0_0;
  localparam logic [16:0] E_MEMRD    = 17'b0_1_0_0_0_0_0_0_00_00_010_0_0;
  localparam logic [16:0] E_MEMWB    = 17'b0_0_0_0_0_1_1_0_00_00_010_0_0;
  localparam logic [16:0] E_MEMWR    = 17'b0_1_1_0_0_0_0_0_00_00_010_0_0;
  localparam logic [16:0] E_EXEC_SUB = 17'b0_0_0_0_0_0_0_1_00_00_110_0_0;
  localparam logic [16:0] E_EXEC_SLT = 17'b0_0_0_0_0_0_0_1_00_00_111_0_0;
  localparam logic [16:0] E_ALUWB    = 17'b0_0_0_0_1_0_1_0_00_00_010_0_0;
  localparam logic [16:0] E_BR_T     = 17'b1_0_0_0_0_0_0_1_00_01_110_0_0;
  localparam logic [16:0] E_BR_N     = 17'b0_0_0_0_0_0_0_1_00_01_110_0_0;
  localparam logic [16:0] E_ADDIWB   = 17'b0_0_0_0_0_0_1_0_00_00_010_0_0;
  localparam logic [16:0] E_JUMP     = 17'b1_0_0_0_0_0_0_0_00_10_010_0_0;
  localparam logic [16:0] E_HALT     = 17'b0_0_0_0_0_0_0_0_00_00_010_1_0;
  localparam logic [16:0] E_HALT_ERR = 17'b0_0_0_0_0_0_0_0_00_00_010_1_1;

  mips_mc_control #(.TIMEOUT(16), .ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .mem2reg(mem2reg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alu_control(alu_control),
    .halted(halted), .err(err)
  );

  assign obs = {pcen, iord, memwrite, irwrite, regdst, mem2reg, regwrite, alusrca,
                alusrcb, pcsrc, alu_control, halted, err};

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = T_LW; funct = 6'b0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== E_FETCH_W) begin
      failures++; $display("FAIL reset_held got=%b exp=%b", obs, E_FETCH_W);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== E_FETCH_W) begin
      failures++; $display("FAIL reset_release got=%b exp=%b", obs, E_FETCH_W);
    end
  endtask

  task automatic test_lw();
    logic [16:0] exp [5] = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB};
    opcode = T_LW;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      checks++;
      if (obs !== exp[i]) begin
        failures++; $display("FAIL lw cyc%0d got=%b exp=%b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_sw();
    logic [16:0] exp [8] = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMWR, E_MEMWR, E_MEMWR,
                             E_MEMWR, E_FETCH_W};
    logic [7:0] rdy = 8'b0100_0111;
    opcode = T_SW;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); mem_ready = rdy[i]; #1;
      checks++;
      if (obs !== exp[i]) begin
        failures++; $display("FAIL sw cyc%0d got=%b exp=%b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [16:0] exp [8] = '{E_FETCH_R, E_DECODE, E_EXEC_SUB, E_ALUWB,
                             E_FETCH_R, E_DECODE, E_EXEC_SLT, E_ALUWB};
    opcode = T_R;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); mem_ready = 1'b1; funct = (i < 4) ? 6'b100010 : 6'b101010; #1;
      checks++;
      if (obs !== exp[i]) begin
        failures++; $display("FAIL rtype cyc%0d got=%b exp=%b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_beq();
    logic [16:0] exp [6] = '{E_FETCH_R, E_DECODE, E_BR_T, E_FETCH_R, E_DECODE, E_BR_N};
    opcode = T_BEQ;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); mem_ready = 1'b1; zero = (i == 2); #1;
      checks++;
      if (obs !== exp[i]) begin
        failures++; $display("FAIL beq cyc%0d got=%b exp=%b", i, obs, exp[i]);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_addi_jump();
    logic [16:0] exp [7] = '{E_FETCH_R, E_DECODE, E_MEMADR, E_ADDIWB,
                             E_FETCH_R, E_DECODE, E_JUMP};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); mem_ready = 1'b1; opcode = (i < 4) ? T_ADDI : T_J; #1;
      checks++;
      if (obs !== exp[i]) begin
        failures++; $display("FAIL addi_j cyc%0d got=%b exp=%b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (obs !== E_FETCH_W) begin
        failures++; $display("FAIL timeout_wait cyc%0d got=%b exp=%b", i, obs, E_FETCH_W);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs !== E_HALT_ERR) begin
        failures++; $display("FAIL timeout_halt cyc%0d got=%b exp=%b", i, obs, E_HALT_ERR);
      end
      @(negedge clk); mem_ready = 1'b1; opcode = T_LW;
    end
  endtask

  task automatic test_ready_wins();
    opcode = T_J;
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      #1;
      checks++;
      if (obs !== E_FETCH_W) begin
        failures++; $display("FAIL ready_wins_wait cyc%0d got=%b exp=%b", i, obs, E_FETCH_W);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1; #1;
    checks++;
    if (obs !== E_FETCH_R) begin
      failures++; $display("FAIL ready_wins_edge got=%b exp=%b", obs, E_FETCH_R);
    end
    @(negedge clk); #1;
    checks++;
    if (obs !== E_DECODE) begin
      failures++; $display("FAIL ready_wins_decode got=%b exp=%b", obs, E_DECODE);
    end
    @(negedge clk); #1;
    checks++;
    if (obs !== E_JUMP) begin
      failures++; $display("FAIL ready_wins_jump got=%b exp=%b", obs, E_JUMP);
    end
  endtask

  task automatic test_reset_mid();
    logic [16:0] exp [4] = '{E_FETCH_R, E_DECODE, E_MEMADR, E_MEMRD};
    opcode = T_LW;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = (i < 3); #1;
      checks++;
      if (obs !== exp[i]) begin
        failures++; $display("FAIL reset_mid_lw cyc%0d got=%b exp=%b", i, obs, exp[i]);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== E_FETCH_W) begin
      failures++; $display("FAIL reset_mid_async got=%b exp=%b", obs, E_FETCH_W);
    end
    @(negedge clk); #1;
    checks++;
    if (obs !== E_FETCH_W) begin
      failures++; $display("FAIL reset_mid_held got=%b exp=%b", obs, E_FETCH_W);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_illegal();
    logic [16:0] exp [3] = '{E_FETCH_R, E_DECODE, E_HALT};
    opcode = T_BAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      checks++;
      if (obs !== exp[i]) begin
        failures++; $display("FAIL illegal_op cyc%0d got=%b exp=%b", i, obs, exp[i]);
      end
    end
    apply_reset();
    opcode = T_R; funct = 6'b111111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      checks++;
      if (obs !== exp[i]) begin
        failures++; $display("FAIL illegal_funct cyc%0d got=%b exp=%b", i, obs, exp[i]);
      end
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== E_HALT) begin
      failures++; $display("FAIL illegal_funct_halt got=%b exp=%b", obs, E_HALT);
    end
  endtask

  task automatic test_bne();
`ifdef MIPS_MC_BNE_EN
    logic [16:0] exp [6] = '{E_FETCH_R, E_DECODE, E_BR_T, E_FETCH_R, E_DECODE, E_BR_N};
    localparam int N = 6;
`else
    logic [16:0] exp [3] = '{E_FETCH_R, E_DECODE, E_HALT};
    localparam int N = 3;
`endif
    apply_reset();
    opcode = T_BNE;
    for (int i = 0; i < N; i++) begin
      @(negedge clk); mem_ready = 1'b1; zero = (i == 5); #1;
      checks++;
      if (obs !== exp[i]) begin
        failures++; $display("FAIL bne cyc%0d got=%b exp=%b", i, obs, exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_addi_jump();
    test_timeout();
    test_ready_wins();
    test_reset_mid();
    test_illegal();
    test_bne();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multicycle main controller for the tinymips core: decodes the 32-bit instruction word (OPCODE/FUNCT fields produced by the lw/sw/R-type encoders the benches use) into per-cycle datapath controls.
- Drives alu_control, regwrite, memwrite, mem2reg and friends that the single-cycle datapath currently takes from forced values.
- Sits in DUT beside the datapath; memory accesses stall on a MEM_READY handshake.

Parameters:
- TIMEOUT, 16, max cycles waiting for MEM_READY in a memory state before ERR (1..255).
- ILLEGAL_TRAP, 1, 1 = unknown opcode/funct goes to HALT; 0 = treated as NOP (return to FETCH).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- OPCODE  in  6  instr[31:26] from instruction register.
- FUNCT  in  6  instr[5:0].
- ZERO  in  1  ALU zero flag.
- MEM_READY  in  1  memory completes access this cycle.
- PCEN  out  1  PC write enable.
- IORD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MEMWRITE  out  1  data memory write strobe.
- IRWRITE  out  1  instruction register load.
- REGDST  out  1  write-register select: 1 = rd, 0 = rt.
- MEM2REG  out  1  write-back select: 1 = memory data.
- REGWRITE  out  1  register file write.
- ALUSRCA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSRCB  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- PCSRC  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump.
- ALU_CONTROL  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- HALTED  out  1  in HALT state.
- ERR  out  1  sticky MEM_READY timeout.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT.
- Async reset -> FETCH, wait counter 0, ERR 0.
- Outputs during and after reset are the FETCH decode with MEM_READY low:
  - ALUSRCB = 01, ALU_CONTROL = 010.
  - All other outputs 0.
- Outputs are decoded from state, except for these Mealy terms:
  - FETCH: IRWRITE = MEM_READY; PCWRITE = MEM_READY.
  - MEMWR: MEMWRITE = 1 every cycle held.
  - PCEN = PCWRITE | (BRANCHsel & ZERO).
- FETCH: IORD = 0, ALUSRCA = 0, ALUSRCB = 01, add. Stays until MEM_READY, then -> DECODE.
- DECODE: ALUSRCA = 0, ALUSRCB = 11, add (branch target). Next state by OPCODE:
  - 100011 lw / 101011 sw -> MEMADR.
  - 000000 -> EXEC.
  - 000100 beq -> BRANCH.
  - 001000 addi -> ADDIEX.
  - 000010 j -> JUMP.
  - else -> HALT (ILLEGAL_TRAP = 1) or FETCH.
- MEMADR: ALUSRCA = 1, ALUSRCB = 10, add. -> MEMRD for lw, -> MEMWR for sw.
- MEMRD: IORD = 1. Waits for MEM_READY, then -> MEMWB.
- MEMWB: REGDST = 0, MEM2REG = 1, REGWRITE = 1. -> FETCH.
- MEMWR: IORD = 1, MEMWRITE = 1. Waits for MEM_READY, then -> FETCH.
- EXEC: ALUSRCA = 1, ALUSRCB = 00, ALU_CONTROL from FUNCT:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown funct -> HALT/FETCH per ILLEGAL_TRAP.
  - -> ALUWB.
- ALUWB: REGDST = 1, MEM2REG = 0, REGWRITE = 1. -> FETCH.
- BRANCH: ALUSRCA = 1, ALUSRCB = 00, sub, PCSRC = 01, BRANCHsel = 1. -> FETCH.
- ADDIEX: ALUSRCA = 1, ALUSRCB = 10, add. -> ADDIWB.
- ADDIWB: REGDST = 0, REGWRITE = 1. -> FETCH.
- JUMP: PCSRC = 10, PCWRITE = 1. -> FETCH.
- HALT: all strobes 0, HALTED = 1. Exits only via reset.
- Instruction latency in cycles with zero wait:
  - lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Wait counter (8-bit):
  - Increments each cycle in FETCH/MEMRD/MEMWR with MEM_READY low.
  - Clears on MEM_READY or on state change.
  - Reaching TIMEOUT: ERR <= 1 (sticky), state -> HALT.
  - MEM_READY high on the cycle the counter reaches TIMEOUT: MEM_READY wins, no ERR.
- Reset mid-instruction: immediate FETCH. No partial regwrite/memwrite is emitted after RST_N falls.

Optional Feature:
- Macro MIPS_MC_BNE_EN.
- Defined: OPCODE 000101 (bne) -> BRANCH state with branch condition ~ZERO (BNEsel), latency 3.
- Undefined: 000101 is illegal, handled per ILLEGAL_TRAP.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state_t enum.
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J).
  - funct constants.
  - alu_ctrl_t values (ALU_ADD = 010 etc.).
- One sub-module, mips_alu_dec: combinational FUNCT + aluop[1:0] -> ALU_CONTROL plus illegal flag. The FSM instantiates it.

Test Plan:
- Reset, then lw (OPCODE 100011), MEM_READY always 1.
  -> States FETCH, DECODE, MEMADR, MEMRD, MEMWB; REGWRITE = 1 and MEM2REG = 1 only in cycle 5.
- sw (101011), MEM_READY low for 3 cycles in MEMWR.
  -> MEMWRITE high 4 cycles, IORD = 1, then FETCH; no REGWRITE.
- R-type FUNCT 100010, then 101010.
  -> ALU_CONTROL 110 in EXEC, then 111; REGDST = 1 in ALUWB.
- beq with ZERO = 1, then ZERO = 0.
  -> PCEN pulses once in BRANCH only for ZERO = 1; PCSRC = 01.
- MEM_READY held low in FETCH, TIMEOUT = 16.
  -> ERR = 1 and HALTED = 1 after 16 cycles. Async RST_N low mid-MEMRD -> outputs return to reset values immediately.
- OPCODE 111111 with ILLEGAL_TRAP = 1 -> HALTED. Without MIPS_MC_BNE_EN, 000101 also -> HALTED; with the macro defined, bne with ZERO = 0 -> PCEN pulse.
